// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU/PC+4 results immediately, waits on the data memory for loads.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage #(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_funct3,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_write_en,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_write_data,
    output logic        busy,
    output logic        load_timeout,
    output logic [31:0] retire_count
);

    localparam logic [31:0] TIMEOUT = 32'(LOAD_TIMEOUT);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t      state;
    logic [4:0]  ld_rd;
    logic        ld_reg_write;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr;
    logic [31:0] wait_cnt;

    logic        accept;
    logic        load_expired;
    logic        direct_we;
    logic [31:0] direct_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_LOAD);
    assign accept   = in_valid && in_ready;
    assign direct_we = in_reg_write && (in_rd != 5'd0);

    // Timeout fires on the cycle the count would reach LOAD_TIMEOUT; rvalid in that cycle wins.
    assign load_expired = (TIMEOUT != 32'd0) && ((wait_cnt + 32'd1) == TIMEOUT);

    always_comb begin
        direct_data = (in_wb_sel == 2'd2) ? (in_pc + 32'd4) : in_alu_result;
    end

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (ld_addr)
            2'd0: ld_byte = dmem_rdata[7:0];
            2'd1: ld_byte = dmem_rdata[15:8];
            2'd2: ld_byte = dmem_rdata[23:16];
            2'd3: ld_byte = dmem_rdata[31:24];
            default: ld_byte = dmem_rdata[7:0];
        endcase
        ld_half = ld_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            ld_rd         <= '0;
            ld_reg_write  <= 1'b0;
            ld_funct3     <= '0;
            ld_addr       <= '0;
            rf_write_en   <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
            load_timeout  <= 1'b0;
        end else begin
            rf_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_wb_sel == 2'd1) begin
                            state        <= WAIT_LOAD;
                            wait_cnt     <= '0;
                            ld_rd        <= in_rd;
                            ld_reg_write <= in_reg_write;
                            ld_funct3    <= in_funct3;
                            ld_addr      <= in_alu_result[1:0];
                        end else begin
                            rf_write_en <= direct_we;
                            if (direct_we) begin
                                rf_rd         <= in_rd;
                                rf_write_data <= direct_data;
                            end
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        state       <= IDLE;
                        rf_write_en <= ld_reg_write && (ld_rd != 5'd0);
                        if (ld_reg_write && (ld_rd != 5'd0)) begin
                            rf_rd         <= ld_rd;
                            rf_write_data <= load_data;
                        end
                    end else if (load_expired) begin
                        state        <= IDLE;
                        load_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic        complete;
    logic [31:0] retire_q;

    // Counted on the edge that launches the write pulse, so the count is visible during the pulse.
    assign complete = (accept && (in_wb_sel != 2'd1)) || ((state == WAIT_LOAD) && dmem_rvalid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if (complete) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: transaction-level expectations checked every cycle.
module tb_writeback_stage;

    localparam int unsigned TO = 4;
`ifdef WB_RETIRE_COUNT_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_write_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic        busy;
    logic        load_timeout;
    logic [31:0] retire_count;

    writeback_stage #(.LOAD_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc(in_pc), .in_funct3(in_funct3),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_write_en(rf_write_en), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
        .busy(busy), .load_timeout(load_timeout), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Expected visible outputs for the current cycle.
    logic        m_ready, m_busy, m_we, m_timeout;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int unsigned m_retire;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("busy", 32'(busy), 32'(m_busy));
        check("rf_write_en", 32'(rf_write_en), 32'(m_we));
        check("rf_rd", 32'(rf_rd), 32'(m_rd));
        check("rf_write_data", rf_write_data, m_data);
        check("load_timeout", 32'(load_timeout), 32'(m_timeout));
        check("retire_count", retire_count, RC_EN ? m_retire : 32'd0);
    end

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] b = w >> (8 * a);
        logic [31:0] h = w >> (16 * a[1]);
        case (f3)
            3'b000:  return 32'($signed(b[7:0]));
            3'b100:  return 32'(b[7:0]);
            3'b001:  return 32'($signed(h[15:0]));
            3'b101:  return 32'(h[15:0]);
            default: return w;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ready = 1'b1; m_busy = 1'b0; m_we = 1'b0; m_timeout = 1'b0;
        m_rd = '0; m_data = '0; m_retire = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            tick();
            m_we = 1'b0;
        end
    endtask

    task automatic op(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc);
        in_valid = 1'b1; in_rd = rd; in_reg_write = rw; in_wb_sel = sel;
        in_alu_result = alu; in_pc = pc; in_funct3 = 3'b010;
        tick();
        m_we = rw && (rd != 0);
        if (m_we) begin
            m_rd = rd;
            m_data = (sel == 2'd2) ? pc + 32'd4 : alu;
        end
        m_retire++;
    endtask

    // rv_cycle: WAIT_LOAD cycle (1-based) carrying rvalid; 0 means the memory never answers.
    task automatic do_load(input logic [4:0] rd, input logic rw, input logic [31:0] addr,
                           input logic [2:0] f3, input int rv_cycle, input logic [31:0] rdata);
        in_valid = 1'b1; in_rd = rd; in_reg_write = rw; in_wb_sel = 2'd1;
        in_alu_result = addr; in_pc = 32'h0000_4000; in_funct3 = f3;
        tick();
        in_valid = 1'b0;
        m_we = 1'b0; m_busy = 1'b1; m_ready = 1'b0;
        for (int k = 1; k <= int'(TO); k++) begin
            if (k == rv_cycle) begin
                dmem_rvalid = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata = 32'hDEAD_0000;
            if (k == rv_cycle) begin
                m_busy = 1'b0; m_ready = 1'b1;
                m_we = rw && (rd != 0);
                if (m_we) begin
                    m_rd = rd;
                    m_data = extract(rdata, addr[1:0], f3);
                end
                m_retire++;
                break;
            end
            if (k == int'(TO)) begin
                m_busy = 1'b0; m_ready = 1'b1; m_timeout = 1'b1; m_we = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_wb_sel = '0;
        in_alu_result = '0; in_pc = '0; in_funct3 = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        idle(2);

        op(5'd5, 1'b1, 2'd0, 32'h1234_5678, 32'h0000_0100);
        check("alu_we", 32'(rf_write_en), 32'd1);
        check("alu_rd", 32'(rf_rd), 32'd5);
        check("alu_data", rf_write_data, 32'h1234_5678);
        idle(1);
        check("alu_one_cycle", 32'(rf_write_en), 32'd0);

        op(5'd1, 1'b1, 2'd2, 32'h5555_5555, 32'hFFFF_FFFC);
        check("pc4_wrap", rf_write_data, 32'h0000_0000);
        op(5'd0, 1'b1, 2'd2, 32'h5555_5555, 32'hFFFF_FFFC);
        check("rd0_no_write", 32'(rf_write_en), 32'd0);
        check("rd0_hold_rd", 32'(rf_rd), 32'd1);
        op(5'd31, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'h0);
        op(5'd7, 1'b0, 2'd0, 32'h0BAD_F00D, 32'h0);
        for (int i = 0; i < 4; i++)
            op(5'(i + 10), 1'b1, 2'(i % 4 == 1 ? 0 : i % 4), 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i * 4));
        idle(1);

        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        idle(2);
        dmem_rvalid = 1'b0;

        do_load(5'd3, 1'b1, 32'h0000_1003, 3'b000, 4, 32'h80FF_0000);
        check("lb_data", rf_write_data, 32'hFFFF_FF80);
        check("lb_no_timeout", 32'(load_timeout), 32'd0);
        idle(1);
        do_load(5'd4, 1'b1, 32'h0000_2002, 3'b101, 1, 32'h80FF_0000);
        check("lhu_data", rf_write_data, 32'h0000_80FF);
        do_load(5'd6, 1'b1, 32'h0000_0001, 3'b100, 2, 32'h1234_A5C3);
        check("lbu_data", rf_write_data, 32'h0000_00A5);
        do_load(5'd8, 1'b1, 32'h0000_0003, 3'b001, 3, 32'h9ABC_1234);
        check("lh_hi_data", rf_write_data, 32'hFFFF_9ABC);
        do_load(5'd9, 1'b1, 32'h0000_0000, 3'b001, 1, 32'h0000_8001);
        do_load(5'd10, 1'b1, 32'h0000_0000, 3'b010, 2, 32'hCAFE_BABE);
        do_load(5'd11, 1'b1, 32'h0000_0001, 3'b011, 1, 32'h1111_2222);
        do_load(5'd12, 1'b1, 32'h0000_0002, 3'b110, 1, 32'h3333_4444);
        do_load(5'd0, 1'b1, 32'h0000_0000, 3'b010, 1, 32'h7777_7777);
        do_load(5'd13, 1'b0, 32'h0000_0000, 3'b010, 2, 32'h8888_8888);
        idle(1);

        do_load(5'd14, 1'b1, 32'h0000_0000, 3'b010, 0, 32'h0);
        check("timeout_flag", 32'(load_timeout), 32'd1);
        check("timeout_no_write", 32'(rf_write_en), 32'd0);
        check("timeout_ready", 32'(in_ready), 32'd1);
        idle(1);
        op(5'd15, 1'b1, 2'd0, 32'hA5A5_A5A5, 32'h0);
        idle(2);

        in_valid = 1'b1; in_rd = 5'd16; in_reg_write = 1'b1; in_wb_sel = 2'd1;
        in_alu_result = 32'h0; in_funct3 = 3'b010;
        tick();
        in_valid = 1'b0; m_we = 1'b0; m_busy = 1'b1; m_ready = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        idle(3);
        dmem_rvalid = 1'b0;
        check("reset_no_write_data", rf_write_data, 32'h0);

        op(5'd2, 1'b1, 2'd0, 32'h1, 32'h0);
        op(5'd0, 1'b1, 2'd0, 32'h2, 32'h0);
        do_load(5'd3, 1'b0, 32'h0, 3'b010, 1, 32'h3);
        idle(2);
        check("retire_three", retire_count, RC_EN ? 32'd3 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
